hist2d_count: RTL and testbench

- 2-D histogram accumulator for IQ readout: each strobed sample increments a 16-bit counter at bin (i_bin_coord, q_bin_coord) in an internal 64x64 table.
- After num_data_pts strobes it streams every active bin (count plus coordinates) out, one per cycle, clearing each bin as it is read.
- Sits between the IQ binning stage and the histogram readout/UART path.

---
 rtl/hist2d_pkg.sv | 27 ++
 rtl/hist2d_ram.sv | 22 ++
 rtl/hist2d_count.sv | 194 +++++++++++++++++++
 tb/tb_hist2d_count.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hist2d_pkg.sv
// Shared widths, table geometry and FSM state encoding for the 2-D IQ histogram.
package hist2d_pkg;

    localparam int COORD_W     = 6;
    localparam int COUNT_W     = 16;
    localparam int BNUM_W      = 12;
    localparam int ADDR_W      = 2 * COORD_W;
    localparam int TABLE_SIDE  = 1 << COORD_W;
    localparam int TABLE_DEPTH = 4096;

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        CLEAR,
        ACCUM,
        DRAIN,
        DUMP
    } state_t;

    // Requested bin counts larger than the table side collapse to the full side.
    function automatic logic [COORD_W:0] clamp_bins(input logic [BNUM_W-1:0] n);
        if (n > BNUM_W'(TABLE_SIDE))
            return (COORD_W+1)'(TABLE_SIDE);
        return n[COORD_W:0];
    endfunction

endpackage

// File: rtl/hist2d_ram.sv
// Bin-count table: one synchronous read port and one write port.
// A read and a write to the same address on the same edge return the old contents.
module hist2d_ram
    import hist2d_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COUNT_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [COUNT_W-1:0] rd_data
);

    logic [COUNT_W-1:0] mem [TABLE_DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/hist2d_count.sv
// 2-D histogram accumulator: bins strobed IQ samples into a 64x64 count table,
// then streams and clears every active bin once a batch is complete.
module hist2d_count
    import hist2d_pkg::*;
(
    input  logic               clk100,
    input  logic               rst_n,
    input  logic               data_in,
    input  logic [COORD_W-1:0] i_bin_coord,
    input  logic [COORD_W-1:0] q_bin_coord,
    input  logic [COUNT_W-1:0] num_data_pts,
    input  logic [BNUM_W-1:0]  i_bin_num,
    input  logic [BNUM_W-1:0]  q_bin_num,
    output logic               data_out,
    output logic [COUNT_W-1:0] bin_val,
    output logic [COORD_W-1:0] i_bin_out,
    output logic [COORD_W-1:0] q_bin_out
);

    state_t             state;
    logic [ADDR_W-1:0]  clr_addr;

    logic [COUNT_W-1:0] num_reg;
    logic [COORD_W:0]   ni_reg;
    logic [COORD_W:0]   nq_reg;
    logic [COUNT_W-1:0] sample_cnt;

    logic               s1_valid;
    logic [ADDR_W-1:0]  s1_addr;
    logic               s2_valid;
    logic [ADDR_W-1:0]  s2_addr;
    logic [COUNT_W-1:0] s2_data;

    logic [COORD_W-1:0] scan_i;
    logic [COORD_W-1:0] scan_q;
    logic               scan_done;
    logic               dump_valid;
    logic [ADDR_W-1:0]  dump_addr;

    logic               ram_we;
    logic [ADDR_W-1:0]  ram_waddr;
    logic [COUNT_W-1:0] ram_wdata;
    logic [ADDR_W-1:0]  ram_raddr;
    logic [COUNT_W-1:0] ram_rdata;

    logic               accept;
    logic               in_range;
    logic               latch_cfg;
    logic               last_q;
    logic               last_i;
    logic [COUNT_W-1:0] base_val;
    logic [COUNT_W-1:0] inc_val;

    hist2d_ram u_ram (
        .clk     (clk100),
        .we      (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    assign accept   = (state == ACCUM) && (num_reg != '0) && data_in;
    assign in_range = ({1'b0, i_bin_coord} < ni_reg) && ({1'b0, q_bin_coord} < nq_reg);
    assign last_q   = ({1'b0, scan_q} == nq_reg - (COORD_W+1)'(1));
    assign last_i   = ({1'b0, scan_i} == ni_reg - (COORD_W+1)'(1));

    // The RAM returns pre-write data, so the previous edge's write is forwarded.
    assign base_val = (s2_valid && (s2_addr == s1_addr)) ? s2_data : ram_rdata;
    assign inc_val  = (base_val == COUNT_MAX) ? base_val : base_val + COUNT_W'(1);

    assign ram_raddr = (state == DUMP) ? {scan_i, scan_q} : {i_bin_coord, q_bin_coord};

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = s1_addr;
        ram_wdata = inc_val;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = '0;
        end else if (dump_valid) begin
            ram_we    = 1'b1;
            ram_waddr = dump_addr;
            ram_wdata = '0;
        end else if (s1_valid) begin
            ram_we    = 1'b1;
            ram_waddr = s1_addr;
            ram_wdata = inc_val;
        end
    end

    always_comb begin
        latch_cfg = 1'b0;
        case (state)
            CLEAR:   latch_cfg = (clr_addr == ADDR_W'(TABLE_DEPTH - 1));
            ACCUM:   latch_cfg = (num_reg == '0);
            DUMP:    latch_cfg = scan_done && !dump_valid;
            default: latch_cfg = 1'b0;
        endcase
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            num_reg <= '0;
            ni_reg  <= '0;
            nq_reg  <= '0;
        end else if (latch_cfg) begin
            num_reg <= num_data_pts;
            ni_reg  <= clamp_bins(i_bin_num);
            nq_reg  <= clamp_bins(q_bin_num);
        end
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            clr_addr   <= '0;
            sample_cnt <= '0;
            s1_valid   <= 1'b0;
            s1_addr    <= '0;
            s2_valid   <= 1'b0;
            s2_addr    <= '0;
            s2_data    <= '0;
            scan_i     <= '0;
            scan_q     <= '0;
            scan_done  <= 1'b0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            data_out   <= 1'b0;
            bin_val    <= '0;
            i_bin_out  <= '0;
            q_bin_out  <= '0;
        end else begin
            s1_valid   <= accept && in_range;
            s1_addr    <= {i_bin_coord, q_bin_coord};
            s2_valid   <= ram_we;
            s2_addr    <= ram_waddr;
            s2_data    <= ram_wdata;
            dump_valid <= 1'b0;
            data_out   <= dump_valid;
            if (dump_valid) begin
                bin_val   <= ram_rdata;
                i_bin_out <= dump_addr[ADDR_W-1:COORD_W];
                q_bin_out <= dump_addr[COORD_W-1:0];
            end

            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + ADDR_W'(1);
                    if (clr_addr == ADDR_W'(TABLE_DEPTH - 1))
                        state <= ACCUM;
                end
                ACCUM: begin
                    if (accept) begin
                        if (sample_cnt == num_reg - COUNT_W'(1)) begin
                            sample_cnt <= '0;
                            state      <= DRAIN;
                        end else begin
                            sample_cnt <= sample_cnt + COUNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    scan_i    <= '0;
                    scan_q    <= '0;
                    scan_done <= (ni_reg == '0) || (nq_reg == '0);
                    state     <= DUMP;
                end
                DUMP: begin
                    // Stay until the last read has been presented so no output overlaps ACCUM.
                    if (!scan_done) begin
                        dump_valid <= 1'b1;
                        dump_addr  <= {scan_i, scan_q};
                        if (last_q) begin
                            scan_q <= '0;
                            if (last_i)
                                scan_done <= 1'b1;
                            else
                                scan_i <= scan_i + COORD_W'(1);
                        end else begin
                            scan_q <= scan_q + COORD_W'(1);
                        end
                    end else if (!dump_valid) begin
                        scan_done <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_hist2d_count.sv
// Directed bench for hist2d_count: runs batches and checks every dumped bin
// against hand-computed histograms.
module tb_hist2d_count;
    import hist2d_pkg::*;

    logic               clk100 = 1'b0;
    logic               rst_n;
    logic               data_in;
    logic [COORD_W-1:0] i_bin_coord;
    logic [COORD_W-1:0] q_bin_coord;
    logic [COUNT_W-1:0] num_data_pts;
    logic [BNUM_W-1:0]  i_bin_num;
    logic [BNUM_W-1:0]  q_bin_num;
    logic               data_out;
    logic [COUNT_W-1:0] bin_val;
    logic [COORD_W-1:0] i_bin_out;
    logic [COORD_W-1:0] q_bin_out;

    typedef struct {
        int                 edge_no;
        logic [COUNT_W-1:0] val;
        logic [COORD_W-1:0] i;
        logic [COORD_W-1:0] q;
    } pulse_t;

    pulse_t pulses[$];
    int     edge_cnt = 0;
    int     last_edge = 0;
    int     n_checks = 0;
    int     n_fail = 0;

    hist2d_count dut (
        .clk100       (clk100),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .i_bin_coord  (i_bin_coord),
        .q_bin_coord  (q_bin_coord),
        .num_data_pts (num_data_pts),
        .i_bin_num    (i_bin_num),
        .q_bin_num    (q_bin_num),
        .data_out     (data_out),
        .bin_val      (bin_val),
        .i_bin_out    (i_bin_out),
        .q_bin_out    (q_bin_out)
    );

    always #5 clk100 = ~clk100;

    always @(posedge clk100) edge_cnt <= edge_cnt + 1;

    always @(negedge clk100)
        if (data_out === 1'b1)
            pulses.push_back('{edge_cnt, bin_val, i_bin_out, q_bin_out});

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setConfig(input int num, input int ni, input int nq);
        num_data_pts = COUNT_W'(num);
        i_bin_num    = BNUM_W'(ni);
        q_bin_num    = BNUM_W'(nq);
    endtask

    // n one-cycle strobes at (i,q), each followed by gap idle cycles.
    task automatic applyStimulus(input int i, input int q, input int n, input int gap);
        for (int s = 0; s < n; s++) begin
            @(negedge clk100);
            i_bin_coord = COORD_W'(i);
            q_bin_coord = COORD_W'(q);
            data_in     = 1'b1;
            last_edge   = edge_cnt + 1;
            if (gap > 0) begin
                @(negedge clk100);
                data_in = 1'b0;
                repeat (gap - 1) @(negedge clk100);
            end
        end
        @(negedge clk100);
        data_in = 1'b0;
    endtask

    task automatic waitPulses(input int count, input int limit);
        int waited = 0;
        while (pulses.size() < count && waited < limit) begin
            @(posedge clk100);
            waited++;
        end
    endtask

    // Expected dump: ni*nq consecutive bins in i-major order, one hot bin, rest zero.
    task automatic checkDump(input string name, input int ni, input int nq,
                             input int hi, input int hq, input int hval);
        int total = ni * nq;
        int gaps  = 0;
        waitPulses(total, total + 20);
        repeat (8) @(posedge clk100);
        checkOutput({name, "_count"}, pulses.size(), total);
        if (pulses.size() > 0)
            checkOutput({name, "_latency"}, pulses[0].edge_no, last_edge + 3);
        for (int k = 0; k < pulses.size() && k < total; k++) begin
            int ei = k / nq;
            int eq = k % nq;
            int ev = (ei == hi && eq == hq) ? hval : 0;
            if (pulses[k].edge_no != pulses[0].edge_no + k)
                gaps++;
            checkOutput($sformatf("%s_bin_%0d_%0d", name, ei, eq),
                        {4'b0, pulses[k].i, pulses[k].q, pulses[k].val},
                        {4'b0, COORD_W'(ei), COORD_W'(eq), COUNT_W'(ev)});
        end
        checkOutput({name, "_consecutive"}, gaps, 0);
        pulses.delete();
    endtask

    initial begin
        rst_n       = 1'b0;
        data_in     = 1'b0;
        i_bin_coord = '0;
        q_bin_coord = '0;
        setConfig(10, 10, 10);
        repeat (3) @(negedge clk100);
        checkOutput("reset_data_out", data_out, 0);
        checkOutput("reset_bin_val", bin_val, 0);
        checkOutput("reset_i_bin_out", i_bin_out, 0);
        checkOutput("reset_q_bin_out", q_bin_out, 0);
        rst_n = 1'b1;

        // Strobes during CLEAR must be ignored.
        applyStimulus(3, 2, 3, 0);
        repeat (4100) @(negedge clk100);

        applyStimulus(3, 2, 10, 2);
        setConfig(10, 10, 10);
        checkDump("basic", 10, 10, 3, 2, 10);

        // Second identical batch, with strobes at (5,5) while the dump is running.
        applyStimulus(3, 2, 10, 2);
        setConfig(16, 8, 8);
        waitPulses(5, 200);
        checkOutput("reread_dump_started", pulses.size() >= 5, 1);
        @(negedge clk100);
        i_bin_coord = 6'd5;
        q_bin_coord = 6'd5;
        data_in     = 1'b1;
        repeat (3) @(negedge clk100);
        data_in = 1'b0;
        checkDump("reread", 10, 10, 3, 2, 10);

        applyStimulus(5, 5, 16, 0);
        setConfig(6, 4, 4);
        checkDump("b2b", 8, 8, 5, 5, 16);

        applyStimulus(1, 1, 3, 0);
        applyStimulus(7, 0, 3, 1);
        setConfig(10, 10, 10);
        checkDump("range", 4, 4, 1, 1, 3);

        // Reset in the middle of a dump.
        applyStimulus(3, 2, 10, 0);
        waitPulses(20, 200);
        checkOutput("rst_dump_started", pulses.size() >= 20, 1);
        @(negedge clk100);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_data_out", data_out, 0);
        checkOutput("rst_mid_bin_val", bin_val, 0);
        checkOutput("rst_mid_i_bin_out", i_bin_out, 0);
        checkOutput("rst_mid_q_bin_out", q_bin_out, 0);
        pulses.delete();
        setConfig(4, 3, 3);
        repeat (2) @(negedge clk100);
        rst_n = 1'b1;
        repeat (4100) @(posedge clk100);
        checkOutput("rst_clear_silent", pulses.size(), 0);

        applyStimulus(2, 2, 4, 1);
        setConfig(2, 70, 1);
        checkDump("post_reset", 3, 3, 2, 2, 4);

        applyStimulus(63, 0, 2, 1);
        setConfig(3, 5, 0);
        checkDump("clamp", 64, 1, 63, 0, 2);

        applyStimulus(0, 0, 3, 0);
        setConfig(1, 2, 2);
        checkDump("empty", 5, 0, 0, 0, 0);

        applyStimulus(1, 1, 1, 0);
        setConfig(1, 2, 2);
        checkDump("resume", 2, 2, 1, 1, 1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
